gb_cpu_bus_ctrl: RTL and testbench

Memory bus controller for the Game Boy CPU: the read side of the register file and the producer of its data-bus write requests. It accepts access requests from the control unit and builds the 16-bit address from a register pair or the high page (0xFF00 | r8). It then drives the external memory strobes and, for reads, returns the fetched byte to the register file via `data_bus_req`/`data_bus_data`/`data_bus_wren`. It sits between the control unit, `gb_cpu_regfile` and the system bus.

---
 rtl/gb_cpu_bus_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_gb_cpu_bus_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_bus_ctrl.sv
// Game Boy CPU memory bus controller: builds addresses from the register file and issues reads and writes.
// Latency: accept at edge N, strobes after N, data_bus_wren/done pulse after N+2 (more if memory stalls).
// Backpressure: o_req_ready low in ADDR (and in DATA/WAIT while memory is not ready); requester holds i_req.
//
// Optional feature macro: GB_CPU_BUS_WAIT_EN. When defined, i_mem_ready can stretch
// the DATA phase through a WAIT state. When undefined, i_mem_ready is ignored.
//
// Register encodings (regfile_r8_t = 4 bits, regfile_r16_t = 3 bits, regfile_t = 16 bytes
// packed with byte k at bits [8k+7:8k]):
//   r8 : A=0 F=1 B=2 C=3 D=4 E=5 H=6 L=7 SP_H=8 SP_L=9 PC_H=10 PC_L=11 IR=12 TMP_H=13 TMP_L=14
//   r16: AF=0 BC=1 DE=2 HL=3 SP=4 PC=5 TMP=6 (code 7 is unassigned and reads as 16'h0000)

module gb_cpu_bus_ctrl (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_req,
    input  logic         i_req_write,
    input  logic         i_req_high,
    input  logic [2:0]   i_addr_r16,
    input  logic [3:0]   i_addr_r8,
    input  logic [3:0]   i_src_r8,
    input  logic [3:0]   i_dst_r8,
    input  logic [127:0] i_registers,
    input  logic [7:0]   i_mem_rdata,
    input  logic         i_mem_ready,
    output logic         o_req_ready,
    output logic [15:0]  o_mem_addr,
    output logic [7:0]   o_mem_wdata,
    output logic         o_mem_rd,
    output logic         o_mem_wr,
    output logic [3:0]   o_data_bus_req,
    output logic [7:0]   o_data_bus_data,
    output logic         o_data_bus_wren,
    output logic         o_done
);

    // 8-bit register codes
    localparam logic [3:0] REG_A     = 4'd0;
    localparam logic [3:0] REG_F     = 4'd1;
    localparam logic [3:0] REG_B     = 4'd2;
    localparam logic [3:0] REG_C     = 4'd3;
    localparam logic [3:0] REG_D     = 4'd4;
    localparam logic [3:0] REG_E     = 4'd5;
    localparam logic [3:0] REG_H     = 4'd6;
    localparam logic [3:0] REG_L     = 4'd7;
    localparam logic [3:0] REG_SP_H  = 4'd8;
    localparam logic [3:0] REG_SP_L  = 4'd9;
    localparam logic [3:0] REG_PC_H  = 4'd10;
    localparam logic [3:0] REG_PC_L  = 4'd11;
    localparam logic [3:0] REG_IR    = 4'd12;
    localparam logic [3:0] REG_TMP_H = 4'd13;
    localparam logic [3:0] REG_TMP_L = 4'd14;

    // 16-bit register pair codes
    localparam logic [2:0] REG_AF  = 3'd0;
    localparam logic [2:0] REG_BC  = 3'd1;
    localparam logic [2:0] REG_DE  = 3'd2;
    localparam logic [2:0] REG_HL  = 3'd3;
    localparam logic [2:0] REG_SP  = 3'd4;
    localparam logic [2:0] REG_PC  = 3'd5;
    localparam logic [2:0] REG_TMP = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
`ifdef GB_CPU_BUS_WAIT_EN
        S_DATA,
        S_WAIT
`else
        S_DATA
`endif
    } state_t;

    state_t       r_state;
    logic [3:0]   r_dst;
    logic         r_write;
    logic [15:0]  r_mem_addr;
    logic [7:0]   r_mem_wdata;
    logic         r_mem_rd;
    logic         r_mem_wr;
    logic [3:0]   r_data_bus_req;
    logic [7:0]   r_data_bus_data;
    logic         r_data_bus_wren;
    logic         r_done;

    logic [3:0]   w_hi_sel;
    logic [3:0]   w_lo_sel;
    logic         w_pair_ok;
    logic [15:0]  w_pair_val;
    logic [15:0]  w_addr;
    logic [7:0]   w_wdata;
    logic         w_mem_ok;
    logic         w_in_data;
    logic         w_complete;
    logic         w_accept;

    // Read one byte of the packed register file by its 8-bit register code.
    function automatic logic [7:0] f_reg8(input logic [127:0] regs, input logic [3:0] sel);
        return regs[{sel, 3'b000} +: 8];
    endfunction

    // Map a register pair code onto its high and low byte registers.
    always_comb begin
        w_hi_sel  = REG_A;
        w_lo_sel  = REG_F;
        w_pair_ok = 1'b1;
        case (i_addr_r16)
            REG_AF:  begin w_hi_sel = REG_A;     w_lo_sel = REG_F;     end
            REG_BC:  begin w_hi_sel = REG_B;     w_lo_sel = REG_C;     end
            REG_DE:  begin w_hi_sel = REG_D;     w_lo_sel = REG_E;     end
            REG_HL:  begin w_hi_sel = REG_H;     w_lo_sel = REG_L;     end
            REG_SP:  begin w_hi_sel = REG_SP_H;  w_lo_sel = REG_SP_L;  end
            REG_PC:  begin w_hi_sel = REG_PC_H;  w_lo_sel = REG_PC_L;  end
            REG_TMP: begin w_hi_sel = REG_TMP_H; w_lo_sel = REG_TMP_L; end
            default: w_pair_ok = 1'b0;
        endcase
    end

    assign w_pair_val = w_pair_ok ? {f_reg8(i_registers, w_hi_sel), f_reg8(i_registers, w_lo_sel)}
                                  : 16'h0000;

    // High-page accesses use the fixed 0xFF page; otherwise the pair passes through unchanged.
    assign w_addr  = i_req_high ? {8'hFF, f_reg8(i_registers, i_addr_r8)} : w_pair_val;
    assign w_wdata = f_reg8(i_registers, i_src_r8);

`ifdef GB_CPU_BUS_WAIT_EN
    assign w_mem_ok  = i_mem_ready;
    assign w_in_data = (r_state == S_DATA) || (r_state == S_WAIT);
`else
    // Memory is always ready in this build; the input is deliberately left unobserved.
    assign w_mem_ok  = 1'b1;
    assign w_in_data = (r_state == S_DATA);
    logic  w_unused_mem_ready;
    assign w_unused_mem_ready = i_mem_ready;
`endif

    // The completing cycle of an access doubles as an accept slot for back-to-back traffic.
    assign w_complete  = w_in_data && w_mem_ok;
    assign o_req_ready = (r_state == S_IDLE) || w_complete;
    assign w_accept    = i_req && o_req_ready;

    // Bus FSM: latch request at acceptance, drive strobes for the access, pulse completion.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_dst           <= REG_IR;
            r_write         <= 1'b0;
            r_mem_addr      <= 16'h0000;
            r_mem_wdata     <= 8'h00;
            r_mem_rd        <= 1'b0;
            r_mem_wr        <= 1'b0;
            r_data_bus_req  <= REG_IR;
            r_data_bus_data <= 8'h00;
            r_data_bus_wren <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_data_bus_wren <= 1'b0;
            r_done          <= 1'b0;

            if (w_complete) begin
                r_done   <= 1'b1;
                r_mem_rd <= 1'b0;
                r_mem_wr <= 1'b0;
                if (!r_write) begin
                    r_data_bus_wren <= 1'b1;
                    r_data_bus_req  <= r_dst;
                    r_data_bus_data <= i_mem_rdata;
                end
            end

            // Everything the access needs is captured here so later register file updates
            // (PC/HL increments mid-access) cannot disturb it.
            if (w_accept) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wdata;
                r_dst       <= i_dst_r8;
                r_write     <= i_req_write;
                r_mem_rd    <= !i_req_write;
                r_mem_wr    <= i_req_write;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_complete) begin
                        r_state <= w_accept ? S_ADDR : S_IDLE;
                    end
`ifdef GB_CPU_BUS_WAIT_EN
                    else begin
                        r_state <= S_WAIT;
                    end
`endif
                end
`ifdef GB_CPU_BUS_WAIT_EN
                S_WAIT: begin
                    if (w_complete) begin
                        r_state <= w_accept ? S_ADDR : S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_mem_rd        = r_mem_rd;
    assign o_mem_wr        = r_mem_wr;
    assign o_data_bus_req  = r_data_bus_req;
    assign o_data_bus_data = r_data_bus_data;
    assign o_data_bus_wren = r_data_bus_wren;
    assign o_done          = r_done;

endmodule

// File: tb/tb_gb_cpu_bus_ctrl.sv
// Bench for gb_cpu_bus_ctrl: directed scenarios plus randomized accesses against a
// register-file model that derives addresses and completions from the bus rules.
// Optional GB_CPU_BUS_WAIT_EN build adds the memory wait-state scenario.

module tb_gb_cpu_bus_ctrl;

    localparam logic [3:0] A = 4'd0, F = 4'd1, B = 4'd2, C = 4'd3, D = 4'd4, E = 4'd5;
    localparam logic [3:0] H = 4'd6, L = 4'd7, PCH = 4'd10, PCL = 4'd11;
    localparam logic [3:0] IR = 4'd12, TMPH = 4'd13, TMPL = 4'd14;
    localparam logic [2:0] P_BC = 3'd1, P_HL = 3'd3, P_PC = 3'd5;

    logic         clk;
    logic         reset;
    logic         req;
    logic         req_write;
    logic         req_high;
    logic [2:0]   addr_r16;
    logic [3:0]   addr_r8;
    logic [3:0]   src_r8;
    logic [3:0]   dst_r8;
    logic [127:0] registers;
    logic [7:0]   mem_rdata;
    logic         mem_ready;
    logic         req_ready;
    logic [15:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic         mem_rd;
    logic         mem_wr;
    logic [3:0]   data_bus_req;
    logic [7:0]   data_bus_data;
    logic         data_bus_wren;
    logic         done;

    logic [7:0] regs [16];
    int n_checks = 0;
    int n_fail   = 0;

    gb_cpu_bus_ctrl dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_req          (req),
        .i_req_write    (req_write),
        .i_req_high     (req_high),
        .i_addr_r16     (addr_r16),
        .i_addr_r8      (addr_r8),
        .i_src_r8       (src_r8),
        .i_dst_r8       (dst_r8),
        .i_registers    (registers),
        .i_mem_rdata    (mem_rdata),
        .i_mem_ready    (mem_ready),
        .o_req_ready    (req_ready),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_rd       (mem_rd),
        .o_mem_wr       (mem_wr),
        .o_data_bus_req (data_bus_req),
        .o_data_bus_data(data_bus_data),
        .o_data_bus_wren(data_bus_wren),
        .o_done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        registers = '0;
        for (int i = 0; i < 16; i++) registers[i*8 +: 8] = regs[i];
    end

    // Address a request should produce, from the register pair table or the high page.
    function automatic logic [15:0] model_addr(input logic high, input logic [2:0] p, input logic [3:0] r);
        int hi_idx [7] = '{0, 2, 4, 6, 8, 10, 13};
        if (high) return 16'hFF00 + 16'(regs[r]);
        if (p > 3'd6) return 16'h0000;
        return 16'(regs[hi_idx[p]]) * 16'd256 + 16'(regs[hi_idx[p] + 1]);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic wr, input logic hi, input logic [2:0] p, input logic [3:0] r,
                           input logic [3:0] s, input logic [3:0] d);
        req = 1'b1; req_write = wr; req_high = hi; addr_r16 = p; addr_r8 = r; src_r8 = s; dst_r8 = d;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req = 0; req_write = 0; req_high = 0; addr_r16 = 0; addr_r8 = 0; src_r8 = 0; dst_r8 = 0;
        mem_rdata = 0; mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        #3;
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h expected 0000", mem_addr); end
        n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_wdata: got %h expected 00", mem_wdata); end
        n_checks++; if ({mem_rd, mem_wr} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes: got %b expected 00", {mem_rd, mem_wr}); end
        n_checks++; if (data_bus_req !== IR) begin n_fail++; $display("FAIL rst_dbus_req: got %0d expected %0d", data_bus_req, IR); end
        n_checks++; if (data_bus_data !== 8'h00) begin n_fail++; $display("FAIL rst_dbus_data: got %h expected 00", data_bus_data); end
        n_checks++; if ({data_bus_wren, done} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b expected 00", {data_bus_wren, done}); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
        tick; tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_read_pc;
        regs[PCH] = 8'h01; regs[PCL] = 8'h50; mem_rdata = 8'h3E;
        set_req(1'b0, 1'b0, P_PC, 4'd0, A, IR);
        tick;
        req = 1'b0;
        n_checks++; if (mem_addr !== 16'h0150) begin n_fail++; $display("FAIL pc_addr_c1: got %h expected 0150", mem_addr); end
        n_checks++; if ({mem_rd, mem_wr} !== 2'b10) begin n_fail++; $display("FAIL pc_strb_c1: got %b expected 10", {mem_rd, mem_wr}); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL pc_ready_addr: got %b expected 0", req_ready); end
        tick;
        n_checks++; if ({mem_rd, mem_wr} !== 2'b10) begin n_fail++; $display("FAIL pc_strb_c2: got %b expected 10", {mem_rd, mem_wr}); end
        n_checks++; if ({data_bus_wren, done} !== 2'b00) begin n_fail++; $display("FAIL pc_early_pulse: got %b expected 00", {data_bus_wren, done}); end
        tick;
        n_checks++; if ({data_bus_wren, done} !== 2'b11) begin n_fail++; $display("FAIL pc_pulses: got %b expected 11", {data_bus_wren, done}); end
        n_checks++; if ({data_bus_req, data_bus_data} !== {IR, 8'h3E}) begin n_fail++; $display("FAIL pc_dbus: got %h expected %h", {data_bus_req, data_bus_data}, {IR, 8'h3E}); end
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL pc_rd_drop: got %b expected 0", mem_rd); end
        tick;
        n_checks++; if ({data_bus_wren, done} !== 2'b00) begin n_fail++; $display("FAIL pc_pulse_len: got %b expected 00", {data_bus_wren, done}); end
        n_checks++; if (mem_addr !== 16'h0150) begin n_fail++; $display("FAIL pc_idle_hold: got %h expected 0150", mem_addr); end
    endtask

    task automatic test_write_high;
        regs[C] = 8'h44; regs[A] = 8'h91;
        set_req(1'b1, 1'b1, 3'd0, C, A, TMPL);
        tick;
        req = 1'b0;
        n_checks++; if ({mem_addr, mem_wdata} !== {16'hFF44, 8'h91}) begin n_fail++; $display("FAIL wr_addr_data: got %h expected ff4491", {mem_addr, mem_wdata}); end
        n_checks++; if ({mem_rd, mem_wr} !== 2'b01) begin n_fail++; $display("FAIL wr_strb: got %b expected 01", {mem_rd, mem_wr}); end
        tick; tick;
        n_checks++; if ({data_bus_wren, done} !== 2'b01) begin n_fail++; $display("FAIL wr_pulses: got %b expected 01", {data_bus_wren, done}); end
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL wr_drop: got %b expected 0", mem_wr); end
        tick;
    endtask

    task automatic test_latch_negedge;
        regs[H] = 8'h80; regs[L] = 8'h00; regs[PCH] = 8'h12; regs[PCL] = 8'h00; mem_rdata = 8'h5A;
        set_req(1'b0, 1'b0, P_HL, 4'd0, A, TMPH);
        tick;
        req = 1'b0;
        @(negedge clk);
        regs[L] = 8'h01; regs[PCL] = 8'h01;
        tick;
        n_checks++; if (mem_addr !== 16'h8000) begin n_fail++; $display("FAIL latch_addr: got %h expected 8000", mem_addr); end
        @(negedge clk);
        regs[L] = 8'h02;
        tick;
        n_checks++; if ({data_bus_req, data_bus_data, data_bus_wren} !== {TMPH, 8'h5A, 1'b1}) begin n_fail++; $display("FAIL latch_dbus: got %h expected %h", {data_bus_req, data_bus_data, data_bus_wren}, {TMPH, 8'h5A, 1'b1}); end
        n_checks++; if (mem_addr !== 16'h8000) begin n_fail++; $display("FAIL latch_hold: got %h expected 8000", mem_addr); end
        tick;
    endtask

    task automatic test_high_ffff;
        regs[L] = 8'hFF; mem_rdata = 8'hC3;
        set_req(1'b0, 1'b1, 3'd0, L, B, IR);
        tick;
        req = 1'b0;
        n_checks++; if (mem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL ffff_addr: got %h expected ffff", mem_addr); end
        tick; tick;
        n_checks++; if ({data_bus_wren, data_bus_data} !== {1'b1, 8'hC3}) begin n_fail++; $display("FAIL ffff_data: got %h expected 1c3", {data_bus_wren, data_bus_data}); end
        tick;
    endtask

    task automatic test_back_to_back;
        regs[H] = 8'hC0; regs[L] = 8'h10; regs[B] = 8'hD0; regs[C] = 8'h20; mem_rdata = 8'h34;
        set_req(1'b0, 1'b0, P_HL, 4'd0, A, TMPL);
        tick;
        set_req(1'b0, 1'b0, P_BC, 4'd0, A, TMPH);
        tick;
        n_checks++; if ({mem_addr, req_ready} !== {16'hC010, 1'b1}) begin n_fail++; $display("FAIL b2b_first_hold: got %h expected %h", {mem_addr, req_ready}, {16'hC010, 1'b1}); end
        tick;
        req = 1'b0; mem_rdata = 8'h12;
        n_checks++; if ({data_bus_wren, data_bus_req, data_bus_data} !== {1'b1, TMPL, 8'h34}) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", {data_bus_wren, data_bus_req, data_bus_data}, {1'b1, TMPL, 8'h34}); end
        n_checks++; if ({mem_rd, mem_addr} !== {1'b1, 16'hD020}) begin n_fail++; $display("FAIL b2b_second_addr: got %h expected %h", {mem_rd, mem_addr}, {1'b1, 16'hD020}); end
        tick;
        n_checks++; if ({mem_rd, data_bus_wren} !== 2'b10) begin n_fail++; $display("FAIL b2b_gap: got %b expected 10", {mem_rd, data_bus_wren}); end
        tick;
        n_checks++; if ({data_bus_wren, data_bus_req, data_bus_data} !== {1'b1, TMPH, 8'h12}) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", {data_bus_wren, data_bus_req, data_bus_data}, {1'b1, TMPH, 8'h12}); end
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_end: got %b expected 0", mem_rd); end
        tick;
    endtask

    task automatic test_reset_mid;
        regs[D] = 8'h40; regs[E] = 8'h00; mem_rdata = 8'h77;
        set_req(1'b0, 1'b0, 3'd2, 4'd0, A, TMPL);
        tick;
        req = 1'b0;
        tick;
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({mem_rd, mem_wr, data_bus_wren, done} !== 4'b0000) begin n_fail++; $display("FAIL rmid_drop: got %b expected 0000", {mem_rd, mem_wr, data_bus_wren, done}); end
        n_checks++; if ({req_ready, mem_addr} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL rmid_idle: got %h expected %h", {req_ready, mem_addr}, {1'b1, 16'h0000}); end
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++; if ({data_bus_wren, done} !== 2'b00) begin n_fail++; $display("FAIL rmid_no_write: got %b expected 00", {data_bus_wren, done}); end
        end
        set_req(1'b0, 1'b0, 3'd2, 4'd0, A, TMPL);
        tick;
        req = 1'b0;
        tick; tick;
        #1 reset = 1'b1;
        #1;
        n_checks++; if ({data_bus_wren, done} !== 2'b00) begin n_fail++; $display("FAIL rpulse_drop: got %b expected 00", {data_bus_wren, done}); end
        #1 reset = 1'b0;
        tick;
    endtask

    task automatic test_random;
        logic wr, hi;
        logic [2:0] p;
        logic [3:0] r, s, d;
        logic [15:0] exp_a;
        logic [7:0] exp_wd, rd_byte;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
            wr = 1'($urandom); hi = 1'($urandom);
            p = 3'($urandom_range(0, 6)); r = 4'($urandom_range(0, 14)); s = 4'($urandom_range(0, 14));
            d = 4'($urandom_range(12, 14)); rd_byte = 8'($urandom);
            exp_a = model_addr(hi, p, r); exp_wd = regs[s];
            mem_rdata = rd_byte;
`ifndef GB_CPU_BUS_WAIT_EN
            mem_ready = 1'($urandom);
`endif
            set_req(wr, hi, p, r, s, d);
            tick;
            req = 1'b0;
            n_checks++; if ({mem_addr, mem_wdata} !== {exp_a, exp_wd}) begin n_fail++; $display("FAIL rnd%0d_addr: got %h expected %h", it, {mem_addr, mem_wdata}, {exp_a, exp_wd}); end
            n_checks++; if ({mem_rd, mem_wr, req_ready} !== {!wr, wr, 1'b0}) begin n_fail++; $display("FAIL rnd%0d_strb: got %b expected %b", it, {mem_rd, mem_wr, req_ready}, {!wr, wr, 1'b0}); end
            @(negedge clk);
            for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
`ifndef GB_CPU_BUS_WAIT_EN
            mem_ready = 1'($urandom);
`endif
            tick;
            n_checks++; if ({mem_addr, mem_rd, mem_wr, req_ready, data_bus_wren} !== {exp_a, !wr, wr, 1'b1, 1'b0}) begin n_fail++; $display("FAIL rnd%0d_data: got %h expected %h", it, {mem_addr, mem_rd, mem_wr, req_ready, data_bus_wren}, {exp_a, !wr, wr, 1'b1, 1'b0}); end
            tick;
            n_checks++; if ({done, data_bus_wren, mem_rd, mem_wr} !== {1'b1, !wr, 2'b00}) begin n_fail++; $display("FAIL rnd%0d_done: got %b expected %b", it, {done, data_bus_wren, mem_rd, mem_wr}, {1'b1, !wr, 2'b00}); end
            if (!wr) begin
                n_checks++; if ({data_bus_req, data_bus_data} !== {d, rd_byte}) begin n_fail++; $display("FAIL rnd%0d_dbus: got %h expected %h", it, {data_bus_req, data_bus_data}, {d, rd_byte}); end
            end
            if ($urandom_range(0, 1) == 1) tick;
        end
        mem_ready = 1'b1;
        tick;
    endtask

`ifdef GB_CPU_BUS_WAIT_EN
    task automatic test_wait;
        regs[H] = 8'h9A; regs[L] = 8'hBC; mem_rdata = 8'hE5;
        set_req(1'b0, 1'b0, P_HL, 4'd0, A, TMPH);
        tick;
        req = 1'b0;
        tick;
        mem_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL wait_ready_data: got %b expected 0", req_ready); end
        for (int i = 0; i < 2; i++) begin
            tick;
            n_checks++; if ({mem_addr, mem_rd, req_ready, data_bus_wren, done} !== {16'h9ABC, 1'b1, 3'b000}) begin n_fail++; $display("FAIL wait_hold%0d: got %h expected %h", i, {mem_addr, mem_rd, req_ready, data_bus_wren, done}, {16'h9ABC, 1'b1, 3'b000}); end
        end
        mem_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wait_ready_rel: got %b expected 1", req_ready); end
        tick;
        n_checks++; if ({data_bus_wren, done, data_bus_req, data_bus_data} !== {2'b11, TMPH, 8'hE5}) begin n_fail++; $display("FAIL wait_done: got %h expected %h", {data_bus_wren, done, data_bus_req, data_bus_data}, {2'b11, TMPH, 8'hE5}); end
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_read_pc;
        test_write_high;
        test_latch_negedge;
        test_high_ffff;
        test_back_to_back;
        test_reset_mid;
        test_random;
`ifdef GB_CPU_BUS_WAIT_EN
        test_wait;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
